// File: rtl/mux_arb_pipe.sv
// N-way registered mux (fixed select or round-robin), 1-cycle latency, full throughput, stalls via Out_ready.
// Optional packet lock on In_last/Out_last enabled by `define MUX_ARB_PKT_LOCK_EN.
module mux_arb_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N*WIDTH-1:0] In_data,
  input  logic [N-1:0]       In_valid,
  output logic [N-1:0]       In_ready,
`ifdef MUX_ARB_PKT_LOCK_EN
  input  logic [N-1:0]       In_last,
  output logic               Out_last,
`endif
  input  logic               Mode,
  input  logic [SELW-1:0]    Sel,
  output logic [WIDTH-1:0]   Out_data,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [SELW-1:0]    Out_chan
);

  logic [N-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_nxt;
  logic [SELW-1:0] idx;
  logic            found;
  logic            load;
  logic            xfer;
  logic            locked;
  logic [SELW-1:0] lock_chan;
  logic            pkt_end;

  assign load = ~Out_valid | Out_ready;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    if (locked) begin
      gidx = lock_chan;
      grant[lock_chan] = In_valid[lock_chan];
    end else if (!Mode) begin
      gidx = Sel;
      if (int'(Sel) < N) grant[Sel] = In_valid[Sel];
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = SELW'((int'(rr_ptr) + k) % N);
        if (!found && In_valid[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          gidx        = idx;
        end
      end
    end
  end

  // Reset gating keeps producers from seeing an accept while the output register is held clear.
  assign In_ready = grant & {N{load & Rst_n}};
  assign xfer     = |In_ready;
  assign rr_nxt   = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_data  <= '0;
      Out_chan  <= '0;
      Out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        Out_data  <= In_data[int'(gidx)*WIDTH +: WIDTH];
        Out_chan  <= gidx;
        Out_valid <= 1'b1;
      end else if (Out_ready) begin
        Out_valid <= 1'b0;
      end
      if (xfer && Mode && pkt_end) rr_ptr <= rr_nxt;
    end
  end

`ifdef MUX_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t state, state_nxt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      lock_chan <= '0;
      Out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && state == IDLE) lock_chan <= gidx;
      if (xfer) Out_last <= In_last[gidx];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && !In_last[gidx]) state_nxt = LOCKED;
      LOCKED:  if (xfer && In_last[gidx])  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    locked  = (state == LOCKED);
    pkt_end = In_last[gidx];
  end
`else
  assign locked    = 1'b0;
  assign lock_chan = '0;
  assign pkt_end   = 1'b1;
`endif

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Directed self-checking bench for mux_arb_pipe (N=4 main instance, N=8 instance for select range).
module tb_mux_arb_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   in_last;
  logic         out_last;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_chan;

  logic [255:0] in_data8;
  logic [7:0]   in_valid8;
  logic [7:0]   in_ready8;
  logic [7:0]   in_last8;
  logic         out_last8;
  logic [2:0]   sel8;
  logic [31:0]  out_data8;
  logic         out_valid8;
  logic [2:0]   out_chan8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_arb_pipe #(.WIDTH(32), .N(4)) u_dut (
    .Clk(clk), .Rst_n(rst_n), .In_data(in_data), .In_valid(in_valid), .In_ready(in_ready),
`ifdef MUX_ARB_PKT_LOCK_EN
    .In_last(in_last), .Out_last(out_last),
`endif
    .Mode(mode), .Sel(sel), .Out_data(out_data), .Out_valid(out_valid),
    .Out_ready(out_ready), .Out_chan(out_chan)
  );

  mux_arb_pipe #(.WIDTH(32), .N(8)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .In_data(in_data8), .In_valid(in_valid8), .In_ready(in_ready8),
`ifdef MUX_ARB_PKT_LOCK_EN
    .In_last(in_last8), .Out_last(out_last8),
`endif
    .Mode(1'b0), .Sel(sel8), .Out_data(out_data8), .Out_valid(out_valid8),
    .Out_ready(1'b1), .Out_chan(out_chan8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    in_last  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++;
    if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_cmp++;
    if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    n_cmp++;
    if (out_chan !== 2'd0) begin n_bad++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL release_in_ready got=%b exp=0001", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'hA000_0000) begin
      n_bad++; $display("FAIL release_first_beat got=%b/%0d/%h exp=1/0/a0000000", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0;
    sel  = 2'd2;
    in_data[2*32 +: 32] = 32'hDEADBEEF;
    in_valid = 4'b1111;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_chan !== 2'd2) begin
      n_bad++; $display("FAIL fixed_out got=%b/%h/%0d exp=1/deadbeef/2", out_valid, out_data, out_chan);
    end
    in_valid = 4'b1011;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL fixed_sel_idle got=%b exp=0000", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fixed_drain got=%b exp=0", out_valid); end
    in_data[2*32 +: 32] = 32'hA000_0002;
    in_valid = '0;

    sel8      = 3'd5;
    in_valid8 = 8'b1101_1111;
    #1;
    n_cmp++;
    if (in_ready8 !== 8'h00) begin n_bad++; $display("FAIL n8_sel5_idle got=%b exp=00000000", in_ready8); end
    tick();
    n_cmp++;
    if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL n8_no_beat got=%b exp=0", out_valid8); end
    in_valid8 = 8'b1111_1111;
    #1;
    n_cmp++;
    if (in_ready8 !== 8'b0010_0000) begin n_bad++; $display("FAIL n8_sel5_ready got=%b exp=00100000", in_ready8); end
    tick();
    n_cmp++;
    if (out_data8 !== 32'h5555_0005 || out_chan8 !== 3'd5) begin
      n_bad++; $display("FAIL n8_sel5_out got=%h/%0d exp=55550005/5", out_data8, out_chan8);
    end
    in_valid8 = '0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d;
    logic [3:0]  exp_r;
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_r = 4'b0001 << (k % 4);
      exp_d = 32'hA000_0000 + 32'(k % 4);
      #1;
      n_cmp++;
      if (in_ready !== exp_r) begin n_bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, in_ready, exp_r); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 2'(k % 4) || out_data !== exp_d) begin
        n_bad++; $display("FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, out_valid, out_chan, out_data, k % 4, exp_d);
      end
    end
    in_valid = '0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_none_valid got=%b exp=0000", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready); end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hA000_0000 || out_chan !== 2'd0) begin
        n_bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/a0000000/0", k, out_valid, out_data, out_chan);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 32'hA000_0001) begin
      n_bad++; $display("FAIL bp_release_out got=%b/%0d/%h exp=1/1/a0000001", out_valid, out_chan, out_data);
    end
    in_valid = '0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    tick();
    tick();
    tick();
    mode = 1'b0;
    sel  = 2'd1;
    #1;
    n_cmp++;
    if (out_chan !== 2'd2) begin n_bad++; $display("FAIL ms_held_beat got=%0d exp=2", out_chan); end
    tick();
    n_cmp++;
    if (out_chan !== 2'd1) begin n_bad++; $display("FAIL ms_fixed got=%0d exp=1", out_chan); end
    mode = 1'b1;
    tick();
    n_cmp++;
    if (out_chan !== 2'd3) begin n_bad++; $display("FAIL ms_rr_resume got=%0d exp=3", out_chan); end
    tick();
    n_cmp++;
    if (out_chan !== 2'd0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL ms_rr_wrap got=%0d/%b exp=0/1", out_chan, out_valid);
    end
    in_valid = '0;
  endtask

`ifdef MUX_ARB_PKT_LOCK_EN
  task automatic test_pkt_lock();
    do_reset();
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      in_data[1*32 +: 32] = 32'hB000_0001 + 32'(b);
      in_last = (b == 2) ? 4'b0010 : 4'b0000;
      if (b > 0) mode = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_ready[%0d] got=%b exp=0010", b, in_ready); end
      tick();
      n_cmp++;
      if (out_chan !== 2'd1 || out_data !== 32'hB000_0001 + 32'(b) || out_last !== (b == 2)) begin
        n_bad++; $display("FAIL lock_beat[%0d] got=%0d/%h/%b exp=1/%h/%b", b, out_chan, out_data, out_last,
                          32'hB000_0001 + 32'(b), b == 2);
      end
    end
    in_last = '0;
    tick();
    n_cmp++;
    if (out_chan !== 2'd0 || out_last !== 1'b0) begin
      n_bad++; $display("FAIL lock_after got=%0d/%b exp=0/0", out_chan, out_last);
    end
    mode = 1'b0;
    sel  = 2'd1;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 4'b0000) begin
      n_bad++; $display("FAIL lock_reset got=%b/%b/%b exp=0/0/0000", out_valid, out_last, in_ready);
    end
    tick();
    rst_n = 1'b1;
    sel   = 2'd0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL lock_cleared got=%b exp=0001", in_ready); end
    in_data[1*32 +: 32] = 32'hA000_0001;
    in_valid = '0;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    out_ready = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_valid8 = '0;
    in_last8  = '0;
    sel8      = '0;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = 32'h5555_0000 + 32'(i);
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_mode_switch();
`ifdef MUX_ARB_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
